// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: parametrised single-port data memory for the ATmega328p core.
// After reset or clr_i, a sweep fills every word with a known pattern and then
// serves req/ready accesses. Reads are registered and flagged by valid_o.
// Accesses at addr_i >= DEPTH are flagged by err_o and leave the array untouched.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   req_i    access request, taken only while ready_o=1
//   we_i     1 = write, 0 = read
//   addr_i   word address (AW bits, unsigned)
//   di_i     write data
//   clr_i    one-cycle pulse that starts a re-initialisation sweep (ignored while busy)
//   do_o     registered read data, holds its value between reads
//   valid_o  one-cycle strobe, do_o carries the data of a read accepted on the previous edge
//   ready_o  accepting requests
//   err_o    one-cycle strobe, the accepted request was out of range
//   busy_o   initialisation sweep in progress (always ~ready_o)
module data_mem_ctrl #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 8,
    parameter int unsigned DEPTH     = 33,
    parameter int unsigned INIT_MODE = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] di_i,
    input  logic          clr_i,
    output logic [DW-1:0] do_o,
    output logic          valid_o,
    output logic          ready_o,
    output logic          err_o,
    output logic          busy_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_next;

    logic [DW-1:0] mem [0:DEPTH-1];

    logic          in_range;
    logic          accept;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] fill_val;
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    // Range check done one bit wider so DEPTH == 2**AW is representable.
    assign in_range = ({1'b0, addr_i} < CW'(DEPTH));
    // clr_i takes priority over a request arriving in the same cycle.
    assign accept   = (state == ST_RUN) && req_i && !clr_i;
    assign rd_idx   = IW'(addr_i);
    assign fill_val = (INIT_MODE == 1) ? DW'(cnt) : '0;

    // State and sweep counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: sweep the array once, then serve until clr_i.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_INIT: begin
                if (cnt == AW'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            ST_RUN: begin
                if (clr_i) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // Single write port shared by the sweep and in-range write requests.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = IW'(cnt);
            mem_wdata = fill_val;
        end else if (accept && we_i && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = rd_idx;
            mem_wdata = di_i;
        end
    end

    // Array storage; contents survive reset and are rewritten by the sweep.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered outputs; ready/busy track the state the FSM is entering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            do_o    <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
        end else begin
            valid_o <= accept && !we_i;
            err_o   <= accept && !in_range;
            ready_o <= (state_next == ST_RUN);
            busy_o  <= (state_next != ST_RUN);
            if (accept && !we_i) begin
                do_o <= in_range ? mem[rd_idx] : '0;
            end
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised synchronous data memory for the ATmega328p core. Replaces the fixed 33x8 array with a configurable DW x DEPTH RAM. Adds a sequenced initialisation engine, a req/ready handshake, registered reads with a valid strobe, and out-of-range detection. Sits between the core's load/store unit and the SRAM address space, and drives no tristate outputs.

Parameters:
DW, 8, data width in bits
AW, 8, address width in bits
DEPTH, 33, number of words; must satisfy 1 <= DEPTH <= 2^AW
INIT_MODE, 1, fill pattern: 0 = all zero, 1 = word i holds i truncated to DW bits

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
req_i  in  1  access request; sampled only when ready_o=1
we_i  in  1  1 = write, 0 = read; qualifies req_i
addr_i  in  AW  word address
di_i  in  DW  write data
clr_i  in  1  one-cycle pulse that starts re-initialisation of the whole array
do_o  out  DW  read data, registered
valid_o  out  1  one-cycle strobe, do_o is valid
ready_o  out  1  accepting requests
err_o  out  1  one-cycle strobe, accepted request had addr_i >= DEPTH
busy_o  out  1  initialisation in progress; equals ~ready_o

Behaviour:
- Reset is rst_i, asynchronous, active-high; clock is clk_i.
- On rst_i: state=INIT, cnt=0, do_o=0, valid_o=0, err_o=0, ready_o=0, busy_o=1. Array contents are not cleared by reset itself; the INIT sweep rewrites them.
- FSM states: INIT, RUN.
- INIT: each cycle, mem[cnt] <= fill(cnt) and cnt increments.
  - When cnt==DEPTH-1 is written, move to RUN and clear cnt.
  - ready_o=1 from the first cycle in RUN, so the sweep takes exactly DEPTH cycles after reset release.
  - req_i is ignored in INIT. No ack, no valid, no err. The requester holds its request until ready_o=1.
- RUN, accept condition: req_i & ready_o at a rising edge.
  - Write, in range: mem[addr_i] <= di_i. No valid_o. do_o unchanged.
  - Read, in range: do_o <= mem[addr_i]. valid_o=1 in the following cycle for exactly one cycle. Latency is 1 clock.
  - Read, out of range (addr_i >= DEPTH): do_o <= 0, valid_o=1 and err_o=1 together for one cycle.
  - Write, out of range: write dropped, err_o=1 for one cycle, valid_o stays 0.
  - Back-to-back accepts are allowed every cycle; throughput is 1 access/clock.
  - A read immediately after a write to the same address returns the new data.
- do_o holds its last read value whenever valid_o=0. It is never Z.
- clr_i in RUN: the next state is INIT with cnt=0, and ready_o drops in the next cycle.
  - A req_i in the same cycle as clr_i is ignored; clr_i wins.
  - clr_i during INIT is ignored; the sweep does not restart.
- rst_i asserted mid-INIT or mid-RUN: immediate return to the reset values. The sweep restarts from 0 after release.
- valid_o from a read accepted in the last RUN cycle before clr_i still fires in the next cycle.
- Address comparison is unsigned on the full AW bits. Fill value is cnt truncated/zero-extended to DW.

Test Plan:
- Reset release, DW=8, DEPTH=33, INIT_MODE=1 -> ready_o rises exactly 33 cycles later; then reading addr 0, 5, 32 gives do_o=0x00, 0x05, 0x20 with valid_o one cycle after each accept.
- Write 0xA5 to addr 7, read addr 7 on the very next cycle -> valid_o=1 and do_o=0xA5 the cycle after the read; addr 6 still reads 0x06.
- Read addr 40 (DEPTH=33) -> do_o=0x00, valid_o=1 and err_o=1 same cycle. Write 0x11 to addr 40 -> err_o pulse, no valid_o, and a read of addr 8 (=40 mod 32) still gives 0x08.
- req_i held high during INIT with addr 3 read -> no valid_o until ready_o=1; first valid_o occurs one cycle after ready_o rises, do_o=0x03.
- After writing 0xFF to addr 2, pulse clr_i with req_i=1 -> request ignored, ready_o low for 33 cycles, then addr 2 reads 0x02. Repeat with INIT_MODE=0 -> reads 0x00.
- Assert rst_i at cycle 10 of INIT -> outputs reset immediately; after release, ready_o rises 33 cycles later, not 23.
